// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues single outstanding fetches on the
// SRAM-like instruction bus and presents one fetch packet to the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          ADEL_BIT = 7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_branch_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic [1:0]  tlb_exc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pcplus4_o,
    output logic [31:0] instr_o,
    output logic [7:0]  except_o,
    output logic        is_in_delayslot_o,
    output logic [1:0]  tlb_exc_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    localparam logic [7:0] ADEL_MASK = 8'b1 << ADEL_BIT;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pkt_pc;
    logic [31:0] r_pkt_pcplus4;
    logic [31:0] r_instr;
    logic [7:0]  r_except;
    logic [1:0]  r_tlb_exc;

    logic        w_misaligned;
    logic        w_tlb_fault;
    logic        w_req;
    logic [31:0] w_pcplus4;
    logic [31:0] w_pc_next;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_tlb_fault  = (tlb_exc_i != 2'b00);
    assign w_req        = (r_state == S_REQ) && !w_misaligned && !w_tlb_fault;
    // Wraps naturally at 2^32, so 0xFFFF_FFFC yields 0.
    assign w_pcplus4    = r_pc + 32'd4;
    assign w_pc_next    = branch_taken_i ? branch_target_i : w_pcplus4;

    assign inst_req_o        = w_req;
    assign inst_addr_o       = r_pc;
    assign pc_o              = r_pkt_pc;
    assign pcplus4_o         = r_pkt_pcplus4;
    assign instr_o           = r_instr;
    assign except_o          = r_except;
    assign tlb_exc_o         = r_tlb_exc;
    assign is_in_delayslot_o = id_branch_i;
    assign fetch_stall_o     = (r_state != S_HOLD);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_pkt_pc      <= '0;
            r_pkt_pcplus4 <= '0;
            r_instr       <= '0;
            r_except      <= '0;
            r_tlb_exc     <= '0;
        end else if (flush_i) begin
            r_pc      <= redirect_pc_i;
            r_except  <= '0;
            r_tlb_exc <= '0;
            // An accepted request whose data has not returned must be drained first.
            unique case (r_state)
                S_REQ:     r_state <= (w_req && inst_addr_ok_i) ? S_DISCARD : S_REQ;
                S_WAIT:    r_state <= inst_data_ok_i ? S_REQ : S_DISCARD;
                S_HOLD:    r_state <= S_REQ;
                S_DISCARD: r_state <= inst_data_ok_i ? S_REQ : S_DISCARD;
                default:   r_state <= S_REQ;
            endcase
        end else begin
            unique case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        r_pkt_pc      <= r_pc;
                        r_pkt_pcplus4 <= w_pcplus4;
                        r_instr       <= '0;
                        r_except      <= ADEL_MASK;
                        r_tlb_exc     <= '0;
                        r_state       <= S_HOLD;
                    end else if (w_tlb_fault) begin
                        r_pkt_pc      <= r_pc;
                        r_pkt_pcplus4 <= w_pcplus4;
                        r_instr       <= '0;
                        r_except      <= '0;
                        r_tlb_exc     <= tlb_exc_i;
                        r_state       <= S_HOLD;
                    end else if (inst_addr_ok_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok_i) begin
                        r_pkt_pc      <= r_pc;
                        r_pkt_pcplus4 <= w_pcplus4;
                        r_instr       <= inst_rdata_i;
                        r_except      <= '0;
                        r_tlb_exc     <= '0;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        r_pc      <= w_pc_next;
                        r_except  <= '0;
                        r_tlb_exc <= '0;
                        r_state   <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (inst_data_ok_i) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule
